// File: rtl/arq_pkg.sv
// Shared definitions for the stop-and-wait ARQ link: FSM encoding,
// response types and the even-parity helper used on both link ends.
package arq_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CHECK = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   localparam logic RSP_ACK  = 1'b0;
   localparam logic RSP_NACK = 1'b1;

   // Even-parity bit for up to 32 payload bits; zero-extension does not change it.
   function automatic logic even_par(input logic [31:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/arq_rx_buf.sv
// Synchronous first-word-fall-through FIFO holding accepted payloads
// until the downstream consumer pops them.
module arq_rx_buf
   import arq_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              empty,
   output logic              full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic              push;
   logic              pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   // NOTE: storage has no reset; empty/full come from the reset pointers and count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/arq_rx_fsm.sv
// Stop-and-wait ARQ receiver: checks each frame for parity, sequence and
// buffer space, answers with a one-cycle ACK/NACK and buffers good payloads.
module arq_rx_fsm
   import arq_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_valid,
   output logic              frame_ready,
   input  logic [DATA_W-1:0] frame_data,
   input  logic              frame_seq,
   input  logic              frame_par,
   output logic              ack,
   output logic              nack,
   output logic              ack_seq,
   input  logic              out_rd_en,
   output logic [DATA_W-1:0] out_data,
   output logic              out_empty,
   output logic              out_full,
   output logic              exp_seq,
   output logic [CNT_W-1:0]  par_err_cnt,
   output logic [CNT_W-1:0]  dup_cnt,
   output logic [CNT_W-1:0]  ovf_cnt
);

   logic [1:0]        state;
   logic [DATA_W-1:0] data_r;
   logic              seq_r;
   logic              par_r;
   logic              par_ok;
   logic              is_dup;
   logic              wr_en;
   logic              rsp;

   assign frame_ready = (state == ST_IDLE);
   assign par_ok      = (even_par(32'(data_r)) == par_r);
   assign is_dup      = (seq_r != exp_seq);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      wr_en = 1'b0;
      rsp   = RSP_ACK;
      if (state == ST_CHECK) begin
         if (!par_ok)       rsp   = RSP_NACK;
         else if (is_dup)   rsp   = RSP_ACK;
         else if (out_full) rsp   = RSP_NACK;
         else               wr_en = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         data_r      <= '0;
         seq_r       <= 1'b0;
         par_r       <= 1'b0;
         ack         <= 1'b0;
         nack        <= 1'b0;
         ack_seq     <= 1'b0;
         exp_seq     <= 1'b0;
         par_err_cnt <= '0;
         dup_cnt     <= '0;
         ovf_cnt     <= '0;
      end else begin
         ack  <= 1'b0;
         nack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (frame_valid) begin
                  data_r <= frame_data;
                  seq_r  <= frame_seq;
                  par_r  <= frame_par;
                  state  <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               ack     <= (rsp == RSP_ACK);
               nack    <= (rsp == RSP_NACK);
               ack_seq <= seq_r;
               // Counters hold at all-ones instead of wrapping.
               if (!par_ok) begin
                  if (par_err_cnt != '1) par_err_cnt <= par_err_cnt + 1'b1;
               end else if (is_dup) begin
                  if (dup_cnt != '1) dup_cnt <= dup_cnt + 1'b1;
               end else if (out_full) begin
                  if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
               end
               if (wr_en) exp_seq <= ~exp_seq;
               state <= ST_RESP;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   arq_rx_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (data_r),
      .rd_en   (out_rd_en),
      .rd_data (out_data),
      .empty   (out_empty),
      .full    (out_full)
   );

endmodule

// File: tb/tb_arq_rx_fsm.sv
// Directed bench for arq_rx_fsm: hand-computed frames cover ACK, parity NACK,
// duplicates, overflow (including a pop racing a full CHECK), draining and reset abort.
module tb_arq_rx_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic       frame_valid;
   logic       frame_ready;
   logic [3:0] frame_data;
   logic       frame_seq;
   logic       frame_par;
   logic       ack;
   logic       nack;
   logic       ack_seq;
   logic       out_rd_en;
   logic [3:0] out_data;
   logic       out_empty;
   logic       out_full;
   logic       exp_seq;
   logic [7:0] par_err_cnt;
   logic [7:0] dup_cnt;
   logic [7:0] ovf_cnt;

   int checks = 0;
   int errors = 0;

   logic r_ack, r_nack, r_seq;

   always #5 clk = ~clk;

   arq_rx_fsm #(
      .DATA_W (4),
      .DEPTH  (4),
      .CNT_W  (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .frame_data  (frame_data),
      .frame_seq   (frame_seq),
      .frame_par   (frame_par),
      .ack         (ack),
      .nack        (nack),
      .ack_seq     (ack_seq),
      .out_rd_en   (out_rd_en),
      .out_data    (out_data),
      .out_empty   (out_empty),
      .out_full    (out_full),
      .exp_seq     (exp_seq),
      .par_err_cnt (par_err_cnt),
      .dup_cnt     (dup_cnt),
      .ovf_cnt     (ovf_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Accepted at edge N, response sampled just after N+1, back in IDLE after N+2.
   task automatic send(input logic [3:0] d, input logic s, input logic p, input logic pop_in_check,
                       output logic a, output logic n, output logic as);
      @(negedge clk);
      frame_valid = 1'b1;
      frame_data  = d;
      frame_seq   = s;
      frame_par   = p;
      @(posedge clk);
      #1;
      frame_valid = 1'b0;
      out_rd_en   = pop_in_check;
      @(posedge clk);
      #1;
      out_rd_en = 1'b0;
      a  = ack;
      n  = nack;
      as = ack_seq;
      @(posedge clk);
      #1;
   endtask

   task automatic pop_once();
      @(negedge clk);
      out_rd_en = 1'b1;
      @(posedge clk);
      #1 out_rd_en = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      frame_valid = 1'b0;
      frame_data  = '0;
      frame_seq   = 1'b0;
      frame_par   = 1'b0;
      out_rd_en   = 1'b0;

      do_reset();
      check("rst_ready", frame_ready, 1);
      check("rst_ack", {ack, nack, ack_seq}, 0);
      check("rst_empty", out_empty, 1);
      check("rst_full", out_full, 0);
      check("rst_exp_seq", exp_seq, 0);
      check("rst_cnts", {par_err_cnt, dup_cnt, ovf_cnt}, 0);

      // Good in-order frame.
      send(4'hA, 1'b0, 1'b0, 1'b0, r_ack, r_nack, r_seq);
      check("good_rsp", {r_ack, r_nack, r_seq}, 3'b100);
      check("good_pulse_end", {ack, nack}, 0);
      check("good_data", out_data, 4'hA);
      check("good_empty", out_empty, 0);
      check("good_exp_seq", exp_seq, 1);

      // Bad parity: 4'h2 has odd weight, so par must be 1.
      send(4'h2, 1'b1, 1'b0, 1'b0, r_ack, r_nack, r_seq);
      check("par_rsp", {r_ack, r_nack, r_seq}, 3'b011);
      check("par_cnt", par_err_cnt, 1);
      check("par_exp_seq", exp_seq, 1);
      check("par_head", out_data, 4'hA);

      // Duplicate of the first frame.
      send(4'hA, 1'b0, 1'b0, 1'b0, r_ack, r_nack, r_seq);
      check("dup_rsp", {r_ack, r_nack, r_seq}, 3'b100);
      check("dup_cnt", dup_cnt, 1);
      check("dup_exp_seq", exp_seq, 1);
      check("dup_head", out_data, 4'hA);
      check("dup_full", out_full, 0);

      // Fill the FIFO.
      do_reset();
      send(4'h0, 1'b0, 1'b0, 1'b0, r_ack, r_nack, r_seq);
      check("fill0_rsp", {r_ack, r_nack, r_seq}, 3'b100);
      send(4'hA, 1'b1, 1'b0, 1'b0, r_ack, r_nack, r_seq);
      check("fill1_rsp", {r_ack, r_nack, r_seq}, 3'b101);
      send(4'h3, 1'b0, 1'b0, 1'b0, r_ack, r_nack, r_seq);
      check("fill2_rsp", {r_ack, r_nack, r_seq}, 3'b100);
      send(4'h2, 1'b1, 1'b1, 1'b0, r_ack, r_nack, r_seq);
      check("fill3_rsp", {r_ack, r_nack, r_seq}, 3'b101);
      check("fill_full", out_full, 1);
      check("fill_exp_seq", exp_seq, 0);

      // Overflow with no pop.
      send(4'h7, 1'b0, 1'b1, 1'b0, r_ack, r_nack, r_seq);
      check("ovf_rsp", {r_ack, r_nack, r_seq}, 3'b010);
      check("ovf_cnt", ovf_cnt, 1);
      check("ovf_exp_seq", exp_seq, 0);
      check("ovf_head", out_data, 4'h0);

      // Pop during the full CHECK: still NACK, head 0 leaves.
      send(4'h7, 1'b0, 1'b1, 1'b1, r_ack, r_nack, r_seq);
      check("ovfpop_rsp", {r_ack, r_nack, r_seq}, 3'b010);
      check("ovfpop_cnt", ovf_cnt, 2);
      check("ovfpop_full", out_full, 0);
      check("ovfpop_head", out_data, 4'hA);

      // Resend now fits.
      send(4'h7, 1'b0, 1'b1, 1'b0, r_ack, r_nack, r_seq);
      check("resend_rsp", {r_ack, r_nack, r_seq}, 3'b100);
      check("resend_full", out_full, 1);
      check("resend_exp_seq", exp_seq, 1);

      // Drain in order.
      check("drain0", out_data, 4'hA);
      pop_once();
      check("drain1", out_data, 4'h3);
      pop_once();
      check("drain2", out_data, 4'h2);
      pop_once();
      check("drain3", out_data, 4'h7);
      check("drain3_empty", out_empty, 0);
      pop_once();
      check("drain_empty", out_empty, 1);
      pop_once();
      check("idle_pop_empty", out_empty, 1);
      check("idle_pop_full", out_full, 0);

      // Pointers still coherent after the ignored pop.
      send(4'h5, 1'b1, 1'b0, 1'b0, r_ack, r_nack, r_seq);
      check("post_rsp", {r_ack, r_nack, r_seq}, 3'b101);
      check("post_data", out_data, 4'h5);
      check("post_empty", out_empty, 0);

      // Reset during CHECK aborts the frame.
      @(negedge clk);
      frame_valid = 1'b1;
      frame_data  = 4'h6;
      frame_seq   = 1'b0;
      frame_par   = 1'b0;
      @(posedge clk);
      #1;
      frame_valid = 1'b0;
      rst         = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_rsp", {ack, nack}, 0);
      check("abort_empty", out_empty, 1);
      check("abort_exp_seq", exp_seq, 0);
      check("abort_cnts", {par_err_cnt, dup_cnt, ovf_cnt}, 0);
      check("abort_ready", frame_ready, 1);
      @(posedge clk);
      #1;
      check("abort_rsp_late", {ack, nack}, 0);
      check("abort_empty_late", out_empty, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
